// File: rtl/simon_pkg.sv
// Shared constants, types and FSM encoding for the SIMON 64/96 key expander.
package simon_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned KEY_WORDS  = 3;
  localparam int unsigned KEY_W      = KEY_WORDS * WORD_W;
  localparam int unsigned NUM_ROUNDS = 42;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned Z_W        = 62;

  localparam logic [WORD_W-1:0] C  = 32'hfffffffc;
  localparam logic [Z_W-1:0]    Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

  // Master key as presented on the key port: k2 in the top word, k0 in the bottom.
  typedef struct packed {
    logic [WORD_W-1:0] k2;
    logic [WORD_W-1:0] k1;
    logic [WORD_W-1:0] k0;
  } master_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/simon_key_expander_step.sv
// One combinational SIMON 64/96 key-schedule step: next round key and rotated z sequence.
module simon_key_expander_step
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] k_back3,
  input  logic [WORD_W-1:0] k_prev,
  input  logic [Z_W-1:0]    z_in,
  output logic [WORD_W-1:0] k_next,
  output logic [Z_W-1:0]    z_shifted
);

  logic [WORD_W-1:0] t;

  // k[i] = C ^ z ^ k[i-3] ^ T ^ ror(T,1), T = ror(k[i-1],3); z advances by rotating left.
  always_comb begin
    t         = {k_prev[2:0], k_prev[WORD_W-1:3]};
    k_next    = C ^ WORD_W'(z_in[Z_W-1]) ^ k_back3 ^ t ^ {t[0], t[WORD_W-1:1]};
    z_shifted = {z_in[Z_W-2:0], z_in[Z_W-1]};
  end

endmodule

// File: rtl/simon_key_expander.sv
// SIMON 64/96 key expander: expands a 96-bit master key into 42 stored round keys.
module simon_key_expander
  import simon_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  input  logic [ADDR_W-1:0] rk_addr,
  output logic [WORD_W-1:0] rk_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ROUNDS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(KEY_WORDS);

  state_t            state;
  state_t            state_next;
  logic              load;
  logic              expand;
  logic              last;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_back3;
  logic [ADDR_W-1:0] idx_prev;
  logic [Z_W-1:0]    z_reg;
  logic [Z_W-1:0]    z_next;
  logic [WORD_W-1:0] k_new;
  logic [WORD_W-1:0] mem [NUM_ROUNDS];
  master_key_t       mkey;

  assign mkey = master_key_t'(key);

  // Read pointers for the step; idx is only below 3 straight after reset, where the result is unused.
  assign idx_back3 = (idx >= FIRST_IDX) ? idx - ADDR_W'(3) : '0;
  assign idx_prev  = (idx != '0) ? idx - ADDR_W'(1) : '0;

  simon_key_expander_step u_step (
    .k_back3   (mem[idx_back3]),
    .k_prev    (mem[idx_prev]),
    .z_in      (z_reg),
    .k_next    (k_new),
    .z_shifted (z_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    expand     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        expand = 1'b1;
        if (idx == LAST_IDX) begin
          last       = 1'b1;
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Key storage, index, z sequence and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_ROUNDS; n++) mem[n] <= '0;
      idx        <= '0;
      z_reg      <= Z2;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= last;
      if (load) begin
        mem[0]     <= mkey.k0;
        mem[1]     <= mkey.k1;
        mem[2]     <= mkey.k2;
        z_reg      <= Z2;
        idx        <= FIRST_IDX;
        keys_valid <= 1'b0;
      end
      if (expand) begin
        mem[idx] <= k_new;
        z_reg    <= z_next;
        idx      <= idx + ADDR_W'(1);
      end
      if (last) keys_valid <= 1'b1;
    end
  end

  // Combinational round-key read; unused addresses return zero.
  always_comb begin
    rk_data = '0;
    if (rk_addr <= LAST_IDX) rk_data = mem[rk_addr];
  end

endmodule

// File: doc/simon_key_expander.md
SIMON_KEY_EXPANDER -- requirements
Module: simon_key_expander

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request expansion of key; sampled only in IDLE.
REQ-004 SHALL have port key, input, 96 bits: SIMON 64/96 master key; k0=key[31:0], k1=key[63:32], k2=key[95:64].
REQ-005 SHALL have port busy, output, 1 bit: high while expansion is in progress.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse when all 42 round keys are stored.
REQ-007 SHALL have port keys_valid, output, 1 bit: level, high from done until next accepted start or reset.
REQ-008 SHALL have port rk_addr, input, 6 bits: round-key read index for the downstream round datapath.
REQ-009 SHALL have port rk_data, output, 32 bits: round key k[rk_addr], combinational read.

Function
REQ-010 SHALL implement FSM states IDLE, EXPAND, FINISH.
REQ-011 In IDLE with start=1, SHALL latch k0..k2 into key storage entries 0..2, load z-register with Z2, set index i=3, clear keys_valid, and go to EXPAND.
REQ-012 In EXPAND, each cycle SHALL write k[i] = C ^ z ^ k[i-3] ^ T ^ ror(T,1) into entry i, where T = ror(k[i-1],3), C=32'hfffffffc, and z = current z-register bit 61 in LSB.
REQ-013 Each EXPAND cycle SHALL rotate the 62-bit z-register left by one and increment i.
REQ-014 After writing entry 41 (39 EXPAND cycles), SHALL go to FINISH.
REQ-015 FINISH SHALL assert done for exactly one cycle, set keys_valid=1, and return to IDLE.
REQ-016 Latency: start sampled at edge T gives EXPAND on edges T+1..T+39 and done high in the cycle after edge T+39; total 40 cycles start-to-done.
REQ-017 busy SHALL be high in EXPAND and FINISH, low in IDLE.
REQ-018 start while busy=1 SHALL be ignored; key SHALL be sampled only on the accepting edge.
REQ-019 start in the same cycle as FINISH SHALL be ignored; it is accepted on the first IDLE cycle.
REQ-020 rk_data SHALL return entry rk_addr for rk_addr 0..41 and 32'h0 for rk_addr 42..63.
REQ-021 rk_data reads during expansion SHALL return the current storage contents; only keys_valid=1 guarantees a complete schedule.
REQ-022 Index and round arithmetic SHALL be 6-bit unsigned; i SHALL never exceed 41 in storage writes.

Reset
REQ-023 rst_n low SHALL force IDLE, busy=0, done=0, keys_valid=0, i=0, z-register=Z2, and all 42 storage entries to 0.
REQ-024 Reset asserted during EXPAND SHALL abort expansion; no done pulse SHALL follow.
REQ-025 First start SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-026 Shared package simon_pkg SHALL hold C (32'hfffffffc), Z2 (62'b10101111011100000011010010011000101000010001111110010110110011), NUM_ROUNDS=42, KEY_WORDS=3, and the FSM state typedef.
REQ-027 The existing combinational keySchedule step SHALL be instantiated once as the only sub-module, fed with k[i-3], k[i-1], and the z-register; its shifted-z output SHALL drive the z-register next value.

Verification
REQ-028 key=96'h13121110_0b0a0908_03020100, start pulse -> done 40 cycles later; rk_addr 0,1,2 -> 03020100, 0b0a0908, 13121110.
REQ-029 Same key, after done -> rk_addr 3 = ffae9dce and rk_addr 4 = c4facc91; entries 5..41 match the golden SIMON 64/96 model.
REQ-030 start held high for 100 cycles -> exactly one done per 41-cycle IDLE-EXPAND-FINISH period, and busy low for only one cycle between runs.
REQ-031 start pulsed again at cycle 10 of EXPAND with a different key -> ignored; stored keys match the first key.
REQ-032 rst_n pulsed low at cycle 20 of EXPAND -> busy=0, keys_valid=0, no done pulse, and all rk_data reads return 0.
REQ-033 rk_addr=42 and rk_addr=63 -> rk_data=0 in all states.
